// File: rtl/alu_divmod_if.sv
// Handshake and operand/result bundle between the ALU control sequencer and the
// sequential divider.
interface alu_divmod_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/alu_divmod_seq.sv
// Restoring unsigned divider, one quotient bit per clock, feeding the ALU
// Div (quotient) and mod (remainder) mux inputs.
module alu_divmod_seq #(
  parameter int N = 4
) (
  input logic        clk,
  input logic        rst,
  alu_divmod_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic          busy_r;
  logic          done_r;
  logic          dbz_r;
  logic [N-1:0]  quot_r;
  logic [N-1:0]  rem_r;

  logic [N:0]    prem;
  logic [N-1:0]  wdiv;
  logic [N-1:0]  dvsr;
  logic [CW-1:0] cnt;

  logic [N:0]    prem_nxt;
  logic [N-1:0]  wdiv_nxt;

  // One restoring iteration: shift {prem, wdiv} left, trial-subtract the divisor
  // at N+1 bits, keep the difference only when it is non-negative.
  function automatic logic [2*N:0] restore_step(input logic [N:0]   pr,
                                                input logic [N-1:0] wd,
                                                input logic [N-1:0] d);
    logic [N:0]        sh;
    logic signed [N:0] trial;
    sh    = {pr[N-1:0], wd[N-1]};
    trial = $signed(sh - {1'b0, d});
    if (trial >= 0) restore_step = {trial, wd[N-2:0], 1'b1};
    else            restore_step = {sh, wd[N-2:0], 1'b0};
  endfunction

  always_comb begin
    {prem_nxt, wdiv_nxt} = restore_step(prem, wdiv, dvsr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      case (state)
        RUN: begin
          prem <= prem_nxt;
          wdiv <= wdiv_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            quot_r <= wdiv_nxt;
            rem_r  <= prem_nxt[N-1:0];
            dbz_r  <= 1'b0;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation, enabling back-to-back use.
          done_r <= 1'b0;
          state  <= IDLE;
          if (bus.start) begin
            dvsr <= bus.b;
            if (bus.b == '0) begin
              quot_r <= '1;
              rem_r  <= bus.a;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              prem   <= '0;
              wdiv   <= bus.a;
              cnt    <= CW'(N - 1);
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
endmodule

// File: tb/tb_alu_divmod_seq.sv
// Self-checking bench for alu_divmod_seq (N=4): directed table, protocol corner
// sequences, exhaustive back-to-back sweep and randomized ops against a model.
module tb_alu_divmod_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_divmod_if #(.N(N)) bus();

  alu_divmod_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] q, output logic [3:0] r,
                                output logic dbz);
    if (b == 0) begin
      q = 4'd15; r = a; dbz = 1'b1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [3:0] ta, input logic [3:0] tv);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tv;
    tick();
    bus.start = 1'b0;
  endtask

  // Called right after launch; returns at the negedge where done is high.
  task automatic finish_op(input logic [3:0] tv, input logic [3:0] eq,
                           input logic [3:0] er, input logic ed,
                           input bit disturb, input string tag);
    int lat = 0;
    chk({tag, " busy_after_start"}, bus.busy, (tv != 0));
    while (!bus.done && lat < 20) begin
      if (disturb && lat == 1) begin
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd1;
      end else if (disturb && lat == 2) begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, (tv == 0) ? 0 : N);
    chk({tag, " busy_at_done"}, bus.busy, 0);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, bus.remainder, er);
    chk({tag, " div_by_zero"}, bus.div_by_zero, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] mq, mr;
    logic       md;
    int         seen;

    tbl[0] = '{a: 4'd13, b: 4'd4, q: 4'd3,  r: 4'd1, dbz: 1'b0};
    tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, dbz: 1'b0};
    tbl[2] = '{a: 4'd3,  b: 4'd7, q: 4'd0,  r: 4'd3, dbz: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd9, q: 4'd0,  r: 4'd0, dbz: 1'b0};
    tbl[4] = '{a: 4'd5,  b: 4'd0, q: 4'd15, r: 4'd5, dbz: 1'b1};
    tbl[5] = '{a: 4'd8,  b: 4'd2, q: 4'd4,  r: 4'd0, dbz: 1'b0};

    // Reset held with start asserted
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 4'd13;
    bus.b = 4'd4;
    @(negedge clk);
    tick();
    tick();
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset quotient", bus.quotient, 0);
    chk("reset remainder", bus.remainder, 0);
    chk("reset div_by_zero", bus.div_by_zero, 0);
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    chk("post_reset busy", bus.busy, 0);
    chk("post_reset done", bus.done, 0);

    // Directed table, each op from idle
    for (int i = 0; i < 6; i++) begin
      launch(tbl[i].a, tbl[i].b);
      finish_op(tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, 1'b0, $sformatf("tbl%0d", i));
      tick();
      chk($sformatf("tbl%0d done_pulse_end", i), bus.done, 0);
      tick();
      chk($sformatf("tbl%0d hold_quotient", i), bus.quotient, tbl[i].q);
      chk($sformatf("tbl%0d hold_remainder", i), bus.remainder, tbl[i].r);
    end

    // Start pulsed mid-RUN with new operands is ignored, then back-to-back 9/2
    launch(4'd14, 4'd3);
    finish_op(4'd3, 4'd4, 4'd2, 1'b0, 1'b1, "midrun");
    launch(4'd9, 4'd2);
    finish_op(4'd2, 4'd4, 4'd1, 1'b0, 1'b0, "b2b");
    tick();

    // Reset on the 2nd RUN cycle
    launch(4'd13, 4'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset busy", bus.busy, 0);
    chk("midreset done", bus.done, 0);
    chk("midreset quotient", bus.quotient, 0);
    chk("midreset remainder", bus.remainder, 0);
    chk("midreset div_by_zero", bus.div_by_zero, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done || bus.busy) seen++;
      tick();
    end
    chk("midreset no_activity", seen, 0);

    // Exhaustive sweep, back-to-back
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ea, eb;
      ea = 4'(i >> 4);
      eb = 4'(i);
      model(ea, eb, mq, mr, md);
      launch(ea, eb);
      finish_op(eb, mq, mr, md, 1'b0, $sformatf("exh a=%0d b=%0d", ea, eb));
    end
    tick();

    // Randomized ops with random gaps
    for (int i = 0; i < 80; i++) begin
      logic [3:0] ra, rb;
      int gap;
      ra = 4'($urandom_range(15));
      rb = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
      gap = $urandom_range(2);
      model(ra, rb, mq, mr, md);
      launch(ra, rb);
      finish_op(rb, mq, mr, md, 1'b0, $sformatf("rnd a=%0d b=%0d", ra, rb));
      for (int g = 0; g < gap; g++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
